except_stage_pipe: RTL and testbench
====================================

# except_stage_pipe

Parametrised per-stage exception merge and pipeline register. It collects `NSRC` local exception sources raised by the instruction in one pipeline stage and picks the highest-priority one. An exception carried from upstream always overrides it. The result is forwarded through `DEPTH` stall/flush-aware register stages toward commit. A HELD state suppresses duplicate exception-happen pulses from younger instructions until the pipeline is flushed.

## Interface
Parameters:
- `NSRC`, 4: number of local exception sources; index 0 has the highest priority; legal range 1..8.
- `DEPTH`, 1: number of register stages between input and `except_o`; legal range 1..4.
- `XLEN`, 64: width of the pc, cause and tval fields.

Ports (all widths are in bits):
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `stall`, input, 1: freezes every register stage and the FSM.
- `flush`, input, 1: clears every stage and returns the FSM to IDLE.
- `valid_i`, input, 1: the instruction in this stage is real.
- `pc_i`, input, XLEN: pc of that instruction.
- `src_req_i`, input, NSRC: per-source exception request.
- `src_cause_i`, input, NSRC×XLEN: packed cause values; source k occupies bits [k*XLEN +: XLEN].
- `src_tval_i`, input, NSRC×XLEN: packed tval values, same packing.
- `except_i`, input, ExceptPack: exception carried from upstream.
- `except_o`, output, ExceptPack: output of the last register stage.
- `except_happen_o`, output, 1: a new local exception is raised this cycle.
- `src_sel_o`, output, max(1,$clog2(NSRC)): index of the winning local source.
- `held_o`, output, 1: the FSM is in HELD.

## Operation
Local selection (combinational):
- A source is eligible when `valid_i & src_req_i[k]`.
- The lowest eligible index k wins.
- The new pack is `{except=1, epc=pc_i, ecause=src_cause_i[k], etval=src_tval_i[k]}`.
- With no eligible source the new pack is all-zero and `src_sel_o`=0.

Merge:
- The stage value is `except_i` if `except_i.except`, otherwise the new pack.
- An upstream exception always wins, even over valid local sources.

`except_happen_o` = any eligible source & ~`except_i.except` & ~held & ~`flush`.
- It is combinational and is not gated by `stall`.
- Consumers must qualify it with ~`stall`.

FSM states:
- IDLE → HELD on an edge where ~`stall` & ~`flush` & the merged `except`=1 is written into stage 0.
- HELD → IDLE on any edge with `flush`=1.
- `flush` takes priority over the IDLE→HELD transition on the same edge.
- With `stall`=1 and `flush`=0 the state is unchanged.

While HELD:
- Stages still shift normally.
- Local sources are still merged into the pack.
- Only `except_happen_o` is suppressed.

Register chain:
- stage[0] takes the merged value; stage[i] takes stage[i-1].
- `flush`: all stages become zero on that edge. Flush beats stall.
- `stall` with no `flush`: all stages hold.
- `except_o` = stage[DEPTH-1].

Reset (`rst`=0, asynchronous):
- All stages are zero, so `except_o` = {0,0,0,0}.
- FSM is IDLE, so `held_o`=0.
- `except_happen_o` and `src_sel_o` follow their combinational inputs.

## Timing
- Latency from input to `except_o` is exactly `DEPTH` unstalled edges. Stalled edges add zero progress.
- `except_happen_o` and `src_sel_o` have 0-cycle latency.
- `held_o` rises on the edge that captures the first exception and falls on the flush edge.
- On simultaneous `flush`+`stall`+exception: the stages are cleared, the FSM goes to IDLE, and the exception is discarded.
- When reset is released mid-stream, the first valid edge behaves as if from IDLE with empty stages.
- `valid_i`=0 with `src_req_i`≠0: the sources are ignored. `except_i` is still passed through.

## Structure
- `ExceptStruct` package, shared and already in the design: `ExceptPack` = {except, epc[XLEN], ecause[XLEN], etval[XLEN]}.
- Add the FSM state enum (IDLE, HELD) to `ExceptStruct`.
- One sub-module: `except_prio_sel`, a parametrised NSRC priority selector returning the winning index and its cause/tval.
- The register chain is a generate loop with no separate module.

## Test plan
- NSRC=4, DEPTH=1, pc_i=0x1000, src_req_i=4'b1010, cause[1]=2, cause[3]=5 → `src_sel_o`=1, `except_happen_o`=1; next edge `except_o`={1,0x1000,2,tval[1]}, `held_o`=1.
- `except_i`={1,0x2000,0xD,0x44} together with src_req_i=4'b0001 → `except_happen_o`=0; `except_o` equals `except_i` after 1 edge.
- In HELD, a new local request at pc 0x1004 → `except_happen_o`=0 and the pack is still shifted through. Then flush=1 → `except_o`=0 and `held_o`=0 on the same edge.
- DEPTH=3: exception at t0 with stall high at t1 → `except_o` is valid after 4 edges and holds during the stall.
- flush=1, stall=1 and src_req_i=1 on the same edge → all stages are zero and the state is IDLE.
- Assert rst=0 asynchronously mid-cycle with stages full → `except_o`=0 and `held_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/except_stage_pipe_pkg.sv
// Shared exception pack type and FSM state for the per-stage exception merge pipeline.
// Imported by the interface, the priority selector and the top.
package ExceptStruct;

  localparam int EXLEN = 64;

  typedef struct packed {
    logic             except;
    logic [EXLEN-1:0] epc;
    logic [EXLEN-1:0] ecause;
    logic [EXLEN-1:0] etval;
  } ExceptPack;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } ExceptState;

  // Select-index width; a single source still needs one bit.
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/except_stage_pipe_if.sv
// Bus bundle of the exception stage: control, local sources and upstream pack in,
// merged pack and status out.
interface except_stage_pipe_if
  import ExceptStruct::*;
#(
  parameter int NSRC = 4,
  parameter int XLEN = 64
) ();

  localparam int SELW = selWidth(NSRC);

  logic                 stall;
  logic                 flush;
  logic                 valid_i;
  logic [XLEN-1:0]      pc_i;
  logic [NSRC-1:0]      src_req_i;
  logic [NSRC*XLEN-1:0] src_cause_i;
  logic [NSRC*XLEN-1:0] src_tval_i;
  ExceptPack            except_i;
  ExceptPack            except_o;
  logic                 except_happen_o;
  logic [SELW-1:0]      src_sel_o;
  logic                 held_o;

  modport master (
    output stall, flush, valid_i, pc_i, src_req_i, src_cause_i, src_tval_i, except_i,
    input  except_o, except_happen_o, src_sel_o, held_o
  );

  modport slave (
    input  stall, flush, valid_i, pc_i, src_req_i, src_cause_i, src_tval_i, except_i,
    output except_o, except_happen_o, src_sel_o, held_o
  );

endinterface

// File: rtl/except_stage_pipe_prio_sel.sv
// Fixed-priority selector: the lowest requesting index wins and its cause/tval are
// extracted from the packed source buses.
module except_prio_sel
  import ExceptStruct::*;
#(
  parameter int NSRC = 4,
  parameter int XLEN = 64,
  parameter int SELW = selWidth(NSRC)
) (
  input  logic [NSRC-1:0]      i_req,
  input  logic [NSRC*XLEN-1:0] i_cause,
  input  logic [NSRC*XLEN-1:0] i_tval,
  output logic                 o_any,
  output logic [SELW-1:0]      o_idx,
  output logic [XLEN-1:0]      o_cause,
  output logic [XLEN-1:0]      o_tval
);

  // Scan from the top down so the last hit, the lowest index, is what remains.
  always_comb begin
    o_any   = |i_req;
    o_idx   = '0;
    o_cause = '0;
    o_tval  = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_idx   = SELW'(k);
        o_cause = i_cause[k*XLEN +: XLEN];
        o_tval  = i_tval[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/except_stage_pipe.sv
// Merges local exception sources with the upstream pack, forwards the result through
// DEPTH stall/flush-aware stages, and suppresses repeat exception pulses until flush.
module except_stage_pipe
  import ExceptStruct::*;
#(
  parameter int NSRC  = 4,
  parameter int DEPTH = 1,
  parameter int XLEN  = EXLEN
) (
  input logic                clk,
  input logic                rst,
  except_stage_pipe_if.slave bus
);

  localparam int SELW = selWidth(NSRC);

  logic [NSRC-1:0] w_elig;
  logic            w_any;
  logic [SELW-1:0] w_selIdx;
  logic [XLEN-1:0] w_selCause;
  logic [XLEN-1:0] w_selTval;
  ExceptPack       w_local;
  ExceptPack       w_merged;
  ExceptState      r_state;
  ExceptState      w_stateNext;
  ExceptPack       r_stage [DEPTH];

  assign w_elig = {NSRC{bus.valid_i}} & bus.src_req_i;

  except_prio_sel #(
    .NSRC (NSRC),
    .XLEN (XLEN),
    .SELW (SELW)
  ) u_prio_sel (
    .i_req   (w_elig),
    .i_cause (bus.src_cause_i),
    .i_tval  (bus.src_tval_i),
    .o_any   (w_any),
    .o_idx   (w_selIdx),
    .o_cause (w_selCause),
    .o_tval  (w_selTval)
  );

  always_comb begin
    w_local = '0;
    if (w_any) begin
      w_local.except = 1'b1;
      w_local.epc    = bus.pc_i;
      w_local.ecause = w_selCause;
      w_local.etval  = w_selTval;
    end
    w_merged = bus.except_i.except ? bus.except_i : w_local;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Flush always wins; entering HELD needs an exception actually captured by stage 0.
  always_comb begin
    w_stateNext = r_state;
    if (bus.flush) begin
      w_stateNext = IDLE;
    end else if (!bus.stall && (r_state == IDLE) && w_merged.except) begin
      w_stateNext = HELD;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stage[i] <= '0;
      end else if (bus.flush) begin
        r_stage[i] <= '0;
      end else if (!bus.stall) begin
        if (i == 0) begin
          r_stage[i] <= w_merged;
        end else begin
          r_stage[i] <= r_stage[(i > 0) ? i - 1 : 0];
        end
      end
    end
  end

  assign bus.except_o        = r_stage[DEPTH-1];
  assign bus.held_o          = (r_state == HELD);
  assign bus.src_sel_o       = w_selIdx;
  assign bus.except_happen_o = w_any & ~bus.except_i.except & (r_state != HELD) & ~bus.flush;

endmodule

// File: tb/tb_except_stage_pipe.sv
// Directed bench: a DEPTH=1 and a DEPTH=3 instance, hand-computed expected packs.
module tb_except_stage_pipe;
  import ExceptStruct::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  except_stage_pipe_if #(.NSRC(4), .XLEN(64)) if1 ();
  except_stage_pipe_if #(.NSRC(4), .XLEN(64)) if3 ();

  except_stage_pipe #(.NSRC(4), .DEPTH(1), .XLEN(64)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  except_stage_pipe #(.NSRC(4), .DEPTH(3), .XLEN(64)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ExceptPack mkPack(input logic e, input logic [63:0] pc,
                                       input logic [63:0] cause, input logic [63:0] tval);
    ExceptPack p;
    p.except = e;
    p.epc    = pc;
    p.ecause = cause;
    p.etval  = tval;
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the DEPTH=1 instance's control and request inputs.
  task automatic applyStimulus(input logic stall, input logic flush, input logic valid,
                               input logic [63:0] pc, input logic [3:0] req);
    if1.stall     = stall;
    if1.flush     = flush;
    if1.valid_i   = valid;
    if1.pc_i      = pc;
    if1.src_req_i = req;
    #1;
  endtask

  task automatic setSrc(input int k, input logic [63:0] cause, input logic [63:0] tval);
    if1.src_cause_i[k*64 +: 64] = cause;
    if1.src_tval_i[k*64 +: 64]  = tval;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b0;
    if1.stall = 0; if1.flush = 0; if1.valid_i = 0; if1.pc_i = '0;
    if1.src_req_i = '0; if1.src_cause_i = '0; if1.src_tval_i = '0; if1.except_i = '0;
    if3.stall = 0; if3.flush = 0; if3.valid_i = 0; if3.pc_i = '0;
    if3.src_req_i = '0; if3.src_cause_i = '0; if3.src_tval_i = '0; if3.except_i = '0;
    setSrc(0, 64'h7, 64'h70);
    setSrc(1, 64'h2, 64'h11);
    setSrc(2, 64'h9, 64'h99);
    setSrc(3, 64'h5, 64'h33);
    #2;
    checkOutput("rst_except_o", 256'(if1.except_o), 256'(0));
    checkOutput("rst_held", 256'(if1.held_o), 256'(0));
    checkOutput("rst_except_o_d3", 256'(if3.except_o), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    // Two requesters: source 1 beats source 3.
    applyStimulus(0, 0, 1, 64'h1000, 4'b1010);
    checkOutput("sel_idx", 256'(if1.src_sel_o), 256'(1));
    checkOutput("happen_first", 256'(if1.except_happen_o), 256'(1));
    tick();
    checkOutput("pack_first", 256'(if1.except_o), 256'(mkPack(1, 64'h1000, 64'h2, 64'h11)));
    checkOutput("held_rise", 256'(if1.held_o), 256'(1));
    checkOutput("happen_held", 256'(if1.except_happen_o), 256'(0));

    // Younger exception while HELD still travels down the chain.
    applyStimulus(0, 0, 1, 64'h1004, 4'b0001);
    checkOutput("happen_held2", 256'(if1.except_happen_o), 256'(0));
    checkOutput("sel_idx0", 256'(if1.src_sel_o), 256'(0));
    tick();
    checkOutput("pack_held", 256'(if1.except_o), 256'(mkPack(1, 64'h1004, 64'h7, 64'h70)));
    applyStimulus(0, 1, 0, 64'h0, 4'b0000);
    tick();
    checkOutput("flush_pack", 256'(if1.except_o), 256'(0));
    checkOutput("flush_held", 256'(if1.held_o), 256'(0));

    // Upstream exception overrides a valid local request.
    if1.except_i = mkPack(1, 64'h2000, 64'hD, 64'h44);
    applyStimulus(0, 0, 1, 64'h1008, 4'b0001);
    checkOutput("happen_upstream", 256'(if1.except_happen_o), 256'(0));
    tick();
    checkOutput("pack_upstream", 256'(if1.except_o), 256'(mkPack(1, 64'h2000, 64'hD, 64'h44)));
    checkOutput("held_upstream", 256'(if1.held_o), 256'(1));
    if1.except_i = '0;
    applyStimulus(0, 1, 0, 64'h0, 4'b0000);
    tick();

    // Invalid instruction: requests ignored.
    applyStimulus(0, 0, 0, 64'h100C, 4'b1111);
    checkOutput("invalid_happen", 256'(if1.except_happen_o), 256'(0));
    checkOutput("invalid_sel", 256'(if1.src_sel_o), 256'(0));
    tick();
    checkOutput("invalid_pack", 256'(if1.except_o), 256'(0));
    checkOutput("invalid_held", 256'(if1.held_o), 256'(0));

    // Stall freezes the stage and FSM but not the combinational pulse.
    applyStimulus(1, 0, 1, 64'h1010, 4'b0100);
    checkOutput("stall_happen", 256'(if1.except_happen_o), 256'(1));
    checkOutput("stall_sel", 256'(if1.src_sel_o), 256'(2));
    tick();
    checkOutput("stall_pack", 256'(if1.except_o), 256'(0));
    checkOutput("stall_held", 256'(if1.held_o), 256'(0));
    applyStimulus(0, 0, 1, 64'h1010, 4'b0100);
    tick();
    checkOutput("unstall_pack", 256'(if1.except_o), 256'(mkPack(1, 64'h1010, 64'h9, 64'h99)));
    checkOutput("unstall_held", 256'(if1.held_o), 256'(1));

    // Flush + stall + exception together: everything cleared.
    applyStimulus(1, 1, 1, 64'h1014, 4'b0001);
    checkOutput("fs_happen", 256'(if1.except_happen_o), 256'(0));
    tick();
    checkOutput("fs_pack", 256'(if1.except_o), 256'(0));
    checkOutput("fs_held", 256'(if1.held_o), 256'(0));

    // Asynchronous reset with the stage full.
    applyStimulus(0, 0, 1, 64'h1018, 4'b0001);
    tick();
    checkOutput("prerst_pack", 256'(if1.except_o), 256'(mkPack(1, 64'h1018, 64'h7, 64'h70)));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_pack", 256'(if1.except_o), 256'(0));
    checkOutput("arst_held", 256'(if1.held_o), 256'(0));
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 1, 64'h101C, 4'b0010);
    checkOutput("postrst_happen", 256'(if1.except_happen_o), 256'(1));
    tick();
    checkOutput("postrst_pack", 256'(if1.except_o), 256'(mkPack(1, 64'h101C, 64'h2, 64'h11)));
    checkOutput("postrst_held", 256'(if1.held_o), 256'(1));
    applyStimulus(0, 0, 0, 64'h0, 4'b0000);

    // DEPTH=3: one stalled edge makes the pack appear after four edges.
    if3.valid_i = 1; if3.pc_i = 64'h3000; if3.src_req_i = 4'b0001;
    if3.src_cause_i[63:0] = 64'h3; if3.src_tval_i[63:0] = 64'h30;
    #1;
    tick();
    checkOutput("d3_held", 256'(if3.held_o), 256'(1));
    if3.valid_i = 0; if3.src_req_i = '0; if3.stall = 1;
    tick();
    checkOutput("d3_edge2", 256'(if3.except_o), 256'(0));
    if3.stall = 0;
    tick();
    checkOutput("d3_edge3", 256'(if3.except_o), 256'(0));
    tick();
    checkOutput("d3_edge4", 256'(if3.except_o), 256'(mkPack(1, 64'h3000, 64'h3, 64'h30)));
    if3.stall = 1;
    tick();
    tick();
    checkOutput("d3_hold", 256'(if3.except_o), 256'(mkPack(1, 64'h3000, 64'h3, 64'h30)));
    if3.stall = 0; if3.flush = 1;
    tick();
    checkOutput("d3_flush", 256'(if3.except_o), 256'(0));
    checkOutput("d3_flush_held", 256'(if3.held_o), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
